// File: rtl/less_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// less_cmp_arbiter
//   Shares one signed 6-bit less-than comparator (twos_compliment_less) between
//   two requesters. Each requester offers an (x,y) pair on a valid/ready port
//   and receives a 1-bit x<y result on its own valid/ready response port.
//   Flow: IDLE (arbitrate, capture operands) -> EVAL (compare) -> RESP (hold
//   the result until the winner takes it) -> IDLE.
//
// Configuration macro:
//   LESS_ARB_FIXED_PRIO_EN  defined   : fixed priority, req0 wins a tie and
//                                       req1 can starve.
//                           undefined : round-robin, a tie goes to the
//                                       requester that was not served last.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   reqN_valid/x/y          operand pair from requester N (two's complement)
//   reqN_ready              pair from requester N accepted this cycle
//   rspN_valid/lt           result for requester N; lt is 0 while valid is 0
//   rspN_ready              requester N takes its result
//   busy                    1 whenever the FSM is not in IDLE
//
// DATA_W must stay 6: the shared comparator is a fixed 6-bit unit.
// -----------------------------------------------------------------------------
module less_cmp_arbiter #(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp0_lt,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    output logic              rsp1_lt,
    input  logic              rsp1_ready,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Shared comparator: only bit 0 of its answer is meaningful, so the
    // helper returns just that bit.
    function automatic logic twos_compliment_less(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return ($signed(a) < $signed(b));
    endfunction

    logic [1:0]        state_r;
    logic [DATA_W-1:0] op_x_r;
    logic [DATA_W-1:0] op_y_r;
    logic              gnt_r;
    logic              last_gnt_r;
    logic              rsp0_valid_r;
    logic              rsp1_valid_r;
    logic              rsp0_lt_r;
    logic              rsp1_lt_r;
    logic              busy_r;

    logic              win_s;
    logic              accept_s;
    logic              cmp_lt_s;
    logic              rsp_take_s;

    // Arbitration: pick the requester that would be served if IDLE now.
    always_comb begin
        win_s = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef LESS_ARB_FIXED_PRIO_EN
            win_s = 1'b0;
`else
            win_s = ~last_gnt_r;
`endif
        end else if (req1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Ready is combinational so a pair can be taken in the cycle it is offered;
    // gating with reset_n keeps every output at 0 while reset is held.
    assign req0_ready = reset_n && (state_r == IDLE) && req0_valid && !win_s;
    assign req1_ready = reset_n && (state_r == IDLE) && req1_valid &&  win_s;
    assign accept_s   = req0_ready || req1_ready;

    assign cmp_lt_s   = twos_compliment_less(op_x_r, op_y_r);
    assign rsp_take_s = gnt_r ? rsp1_ready : rsp0_ready;

    // Main FSM with operand capture and per-port result registers; the result
    // lives only in the granted port's lt flop so the other port reads 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            op_x_r       <= {DATA_W{1'b0}};
            op_y_r       <= {DATA_W{1'b0}};
            gnt_r        <= 1'b0;
            last_gnt_r   <= 1'b1;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_lt_r    <= 1'b0;
            rsp1_lt_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_x_r  <= win_s ? req1_x : req0_x;
                        op_y_r  <= win_s ? req1_y : req0_y;
                        gnt_r   <= win_s;
                        busy_r  <= 1'b1;
                        state_r <= EVAL;
                    end
                end
                EVAL: begin
                    rsp0_valid_r <= ~gnt_r;
                    rsp1_valid_r <=  gnt_r;
                    rsp0_lt_r    <= ~gnt_r & cmp_lt_s;
                    rsp1_lt_r    <=  gnt_r & cmp_lt_s;
                    state_r      <= RESP;
                end
                RESP: begin
                    // rsp_ready on the non-granted port is ignored.
                    if (rsp_take_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        rsp0_lt_r    <= 1'b0;
                        rsp1_lt_r    <= 1'b0;
                        last_gnt_r   <= gnt_r;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    rsp0_lt_r    <= 1'b0;
                    rsp1_lt_r    <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_lt    = rsp0_lt_r;
    assign rsp1_lt    = rsp1_lt_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_less_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_less_cmp_arbiter
//   Directed, self-checking bench for less_cmp_arbiter. Inputs change 2 time
//   units after a rising edge; outputs are sampled there or 1 unit later.
//   Honours LESS_ARB_FIXED_PRIO_EN for the grant-order expectations.
// -----------------------------------------------------------------------------
module tb_less_cmp_arbiter;

    logic       clk;
    logic       reset_n;
    logic       req0_valid, req1_valid;
    logic [5:0] req0_x, req0_y, req1_x, req1_y;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp0_lt, rsp0_ready;
    logic       rsp1_valid, rsp1_lt, rsp1_ready;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    less_cmp_arbiter #(.DATA_W(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_lt    (rsp0_lt),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_lt    (rsp1_lt),
        .rsp1_ready (rsp1_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One uncontested operation from requester `who`, acknowledged at once.
    task automatic do_op(input logic who, input logic [5:0] x, input logic [5:0] y,
                         input logic exp_lt, input string tag);
        if (who) begin
            req1_valid = 1'b1; req1_x = x; req1_y = y;
        end else begin
            req0_valid = 1'b1; req0_x = x; req0_y = y;
        end
        #1;
        chk({tag, "_ready"}, who ? req1_ready : req0_ready, 32'd1);
        chk({tag, "_other_ready"}, who ? req0_ready : req1_ready, 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_eval_busy"}, busy, 32'd1);
        chk({tag, "_eval_novalid"}, who ? rsp1_valid : rsp0_valid, 32'd0);
        tick();
        chk({tag, "_rsp_valid"}, who ? rsp1_valid : rsp0_valid, 32'd1);
        chk({tag, "_rsp_lt"}, who ? rsp1_lt : rsp0_lt, {31'd0, exp_lt});
        chk({tag, "_other_rsp"}, who ? rsp0_valid : rsp1_valid, 32'd0);
        if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk({tag, "_done_valid"}, who ? rsp1_valid : rsp0_valid, 32'd0);
        chk({tag, "_done_busy"}, busy, 32'd0);
    endtask

    logic [5:0] t3_x [5] = '{6'h05, 6'h1F, 6'h20, 6'h3B, 6'h3D};
    logic [5:0] t3_y [5] = '{6'h05, 6'h20, 6'h1F, 6'h3D, 6'h3B};
    logic       t3_lt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef LESS_ARB_FIXED_PRIO_EN
    logic       exp_order[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    logic       exp_order[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

    initial begin
        int   waited;
        logic w;

        reset_n    = 1'b0;
        req0_valid = 1'b1; req0_x = 6'h00; req0_y = 6'h00;
        req1_valid = 1'b1; req1_x = 6'h00; req1_y = 6'h00;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Reset state: everything 0 even with both requesters valid.
        tick();
        tick();
        chk("rst_req0_ready", req0_ready, 32'd0);
        chk("rst_req1_ready", req1_ready, 32'd0);
        chk("rst_rsp0_valid", rsp0_valid, 32'd0);
        chk("rst_rsp1_valid", rsp1_valid, 32'd0);
        chk("rst_rsp0_lt",    rsp0_lt,    32'd0);
        chk("rst_rsp1_lt",    rsp1_lt,    32'd0);
        chk("rst_busy",       busy,       32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset_n    = 1'b1;
        tick();
        chk("post_rst_busy", busy, 32'd0);

        // -2 < 3 from requester 0.
        do_op(1'b0, 6'h3E, 6'h03, 1'b1, "t2");

        // Signed boundaries and equality from requester 1.
        for (int i = 0; i < 5; i++) begin
            do_op(1'b1, t3_x[i], t3_y[i], t3_lt[i], $sformatf("t3_%0d", i));
        end

        // Both held valid for 4 operations; last served was req1.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_x = 6'h01; req0_y = 6'h02;
        req1_valid = 1'b1; req1_x = 6'h02; req1_y = 6'h01;
        for (int i = 0; i < 4; i++) begin
            #1;
            waited = 0;
            while (!(req0_ready || req1_ready) && waited < 8) begin
                tick();
                waited++;
            end
            chk($sformatf("t4_wait_%0d", i), {31'd0, (req0_ready || req1_ready)}, 32'd1);
            w = req1_ready;
            chk($sformatf("t4_grant_%0d", i), {31'd0, w}, {31'd0, exp_order[i]});
            chk($sformatf("t4_both_%0d", i), {31'd0, (req0_ready && req1_ready)}, 32'd0);
            tick();
            tick();
            chk($sformatf("t4_rsp_valid_%0d", i),
                exp_order[i] ? rsp1_valid : rsp0_valid, 32'd1);
            chk($sformatf("t4_rsp_lt_%0d", i),
                exp_order[i] ? rsp1_lt : rsp0_lt, exp_order[i] ? 32'd0 : 32'd1);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Stalled response: -1 < 1, held for several cycles while inputs move.
        req0_valid = 1'b1; req0_x = 6'h3F; req0_y = 6'h01;
        #1;
        chk("t5_ready", req0_ready, 32'd1);
        tick();
        req0_x = 6'h01; req0_y = 6'h3F;
        req1_valid = 1'b1; req1_x = 6'h00; req1_y = 6'h01;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_valid_%0d", i), rsp0_valid, 32'd1);
            chk($sformatf("t5_lt_%0d", i),    rsp0_lt,    32'd1);
            chk($sformatf("t5_busy_%0d", i),  busy,       32'd1);
            chk($sformatf("t5_r0_%0d", i),    req0_ready, 32'd0);
            chk($sformatf("t5_r1_%0d", i),    req1_ready, 32'd0);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("t5_idle_busy",  busy,       32'd0);
        chk("t5_idle_valid", rsp0_valid, 32'd0);

        // Reset while RESP for req0 (last served was req0).
        req0_valid = 1'b1; req0_x = 6'h00; req0_y = 6'h01;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("t1_in_resp", rsp0_valid, 32'd1);
        reset_n    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_x = 6'h02; req1_y = 6'h01;
        #1;
        chk("t1_rsp0_valid", rsp0_valid, 32'd0);
        chk("t1_rsp0_lt",    rsp0_lt,    32'd0);
        chk("t1_rsp1_valid", rsp1_valid, 32'd0);
        chk("t1_busy",       busy,       32'd0);
        chk("t1_req0_ready", req0_ready, 32'd0);
        chk("t1_req1_ready", req1_ready, 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("t1_first_req0", req0_ready, 32'd1);
        chk("t1_first_req1", req1_ready, 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("t1_rsp_valid", rsp0_valid, 32'd1);
        chk("t1_rsp_lt",    rsp0_lt,    32'd1);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("t1_done_busy", busy, 32'd0);

        // Reset pulse during EVAL drops the op.
        req1_valid = 1'b1; req1_x = 6'h10; req1_y = 6'h11;
        #1;
        chk("t6_ready", req1_ready, 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("t6_eval_busy", busy, 32'd1);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
        chk("t6_busy_cleared", busy, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t6_no_rsp0_%0d", i), rsp0_valid, 32'd0);
            chk($sformatf("t6_no_rsp1_%0d", i), rsp1_valid, 32'd0);
        end
        do_op(1'b1, 6'h2A, 6'h15, 1'b1, "t6_next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
